vga_sync_monitor: RTL and testbench
===================================

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Params: H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48, V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33; sync pulses are active-low.
REQ-002 clk  in  1  single system clock; all logic on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 pix_en  in  1  pixel-tick enable; state advances only when pix_en=1.
REQ-005 hSync, vSync  in  1 each  VGA sync inputs from the display controller.
REQ-006 VGA_R, VGA_G, VGA_B  in  4 each  pixel colour.
REQ-007 locked  out  1  timing lock indication.
REQ-008 h_err, v_err  out  1 each  sticky timing-error flags.
REQ-009 active  out  1  current sample lies in the visible window.
REQ-010 x, y  out  10 each  visible pixel coordinate; valid only when active=1.
REQ-011 frame_done  out  1  one-clk pulse at the end of each locked frame.
REQ-012 frame_sum  out  24  checksum of the last completed frame.
REQ-013 frame_cnt  out  8  count of completed locked frames, wraps at 255.

Function
REQ-014 Inputs SHALL be sampled on pix_en ticks; sync edges SHALL be detected against the previous tick's sample.
REQ-015 h_cnt (10b) SHALL clear to 0 on an hSync falling edge, else increment per tick.
REQ-016 v_cnt (10b) SHALL clear to 0 on a vSync falling edge, else increment on each hSync falling edge.
REQ-017 Line check: h_cnt at hSync fall SHALL equal 799; hSync rise SHALL occur at h_cnt 95; either mismatch is a line error.
REQ-018 Frame check: v_cnt at vSync fall SHALL equal 524; vSync rise SHALL occur at v_cnt 2; either mismatch is a frame error.
REQ-019 FSM states: SEARCH, HLOCK, TRACK.
REQ-020 SEARCH -> HLOCK after 4 consecutive error-free lines.
REQ-021 HLOCK -> TRACK on the next vSync falling edge.
REQ-022 Any line error in HLOCK or TRACK SHALL return the FSM to SEARCH and set h_err.
REQ-023 A frame error in TRACK SHALL return the FSM to SEARCH and set v_err.
REQ-024 h_err and v_err SHALL stay set until reset.
REQ-025 locked SHALL be 1 only in TRACK after at least one error-free frame end.
REQ-026 locked SHALL drop on the same clk the FSM leaves TRACK.
REQ-027 active SHALL be 1 when the FSM is in TRACK, 144<=h_cnt<=783 and 35<=v_cnt<=514.
REQ-028 When active=1: x = h_cnt-144, y = v_cnt-35; when active=0, x and y SHALL hold their last values.
REQ-029 frame_done SHALL pulse on a vSync fall ending an error-free frame in TRACK.
REQ-030 On frame_done: frame_sum latches the accumulator, the accumulator clears, frame_cnt increments.
REQ-031 If a sync edge coincides with an error, the error SHALL win: no frame_done, no latch.
REQ-032 Output latency: 1 clk after the sampling tick.

Reset
REQ-033 On reset low: FSM=SEARCH; locked, h_err, v_err, active, frame_done=0.
REQ-034 On reset low: x, y, h_cnt, v_cnt, frame_sum, frame_cnt, accumulator=0; prior sync samples=1.
REQ-035 Reset mid-frame SHALL discard all partial results; relock SHALL require the full REQ-020/021 sequence.

Configuration
REQ-036 With VGA_MON_CHECKSUM_EN defined: the accumulator SHALL add {R,G,B} (12b, zero-extended) per active tick, mod 2^24.
REQ-037 Without VGA_MON_CHECKSUM_EN: no accumulator; frame_sum is constant 0; all other behaviour is unchanged.

Verification
REQ-038 Drive standard 640x480 timing, constant RGB 12'h001, pix_en=1 -> frame_done at end of frame 2; frame_sum=307200 (24'h04B000); locked=1.
REQ-039 Shorten one line to 798 ticks while locked -> locked=0 and h_err=1 next clk; FSM=SEARCH; relock after 4 good lines plus one vSync fall.
REQ-040 Set vSync width to 3 lines -> v_err=1; no frame_done for that frame.
REQ-041 Assert reset low mid-frame -> all outputs 0 asynchronously; after release, frame_cnt restarts at 1 on the first locked frame.
REQ-042 pix_en at 1-in-4 duty with the same tick timing -> identical frame_sum and frame_cnt to REQ-038.
REQ-043 Run 256 locked frames -> frame_cnt wraps to 0; build without the macro -> frame_sum=0 throughout.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: locks onto sync timing, tracks the visible window and counts frames.
// Define VGA_MON_CHECKSUM_EN to add the per-frame RGB checksum accumulator.
module vga_sync_monitor #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [3:0]  VGA_R,
    input  logic [3:0]  VGA_G,
    input  logic [3:0]  VGA_B,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic        active,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_done,
    output logic [23:0] frame_sum,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] HLast = 10'(HTot - 1);
    localparam logic [9:0] HRise = 10'(H_SYNC - 1);
    localparam logic [9:0] HAct0 = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HAct1 = 10'(H_SYNC + H_BP + H_VIS - 1);
    localparam logic [9:0] VLast = 10'(VTot - 1);
    localparam logic [9:0] VRise = 10'(V_SYNC);
    localparam logic [9:0] VAct0 = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VAct1 = 10'(V_SYNC + V_BP + V_VIS - 1);

    typedef enum logic [1:0] {StSearch, StHlock, StTrack} state_t;

    state_t      state_q;
    logic        hs_q, vs_q;
    logic [9:0]  h_cnt_q, v_cnt_q;
    logic [1:0]  good_q;
    logic        line_ok_q;

    logic        h_fall, h_rise, v_fall, v_rise;
    logic [9:0]  h_cnt_n, v_cnt_n;
    logic        line_err, frame_err, line_good;
    logic        done_n, track_n, act_n;

    always_comb begin
        h_fall    = hs_q & ~hSync;
        h_rise    = ~hs_q & hSync;
        v_fall    = vs_q & ~vSync;
        v_rise    = ~vs_q & vSync;
        h_cnt_n   = h_fall ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_n   = v_fall ? 10'd0 : (h_fall ? v_cnt_q + 10'd1 : v_cnt_q);
        line_err  = (h_fall && h_cnt_q != HLast) || (h_rise && h_cnt_q != HRise);
        // The rise is judged by the line it lands in, so it may coincide with an hSync fall.
        frame_err = (v_fall && v_cnt_q != VLast) || (v_rise && v_cnt_n != VRise);
        line_good = h_fall && !line_err && line_ok_q;
        done_n    = (state_q == StTrack) && v_fall && !line_err && !frame_err;
        track_n   = !line_err && (((state_q == StTrack) && !frame_err) ||
                                  ((state_q == StHlock) && v_fall));
        act_n     = track_n && (h_cnt_n >= HAct0) && (h_cnt_n <= HAct1) &&
                    (v_cnt_n >= VAct0) && (v_cnt_n <= VAct1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StSearch;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            good_q     <= '0;
            line_ok_q  <= 1'b0;
            locked     <= 1'b0;
            h_err      <= 1'b0;
            v_err      <= 1'b0;
            active     <= 1'b0;
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (pix_en) begin
                hs_q       <= hSync;
                vs_q       <= vSync;
                h_cnt_q    <= h_cnt_n;
                v_cnt_q    <= v_cnt_n;
                active     <= act_n;
                frame_done <= done_n;
                locked     <= track_n && (locked || done_n);
                if (h_fall) begin
                    line_ok_q <= 1'b1;
                end else if (line_err) begin
                    line_ok_q <= 1'b0;
                end
                if (act_n) begin
                    x <= h_cnt_n - HAct0;
                    y <= v_cnt_n - VAct0;
                end
                if (done_n) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
                unique case (state_q)
                    StSearch: begin
                        // good_q wraps to 0 on the fourth good line, ready for the next search.
                        if (line_good) begin
                            good_q <= good_q + 2'd1;
                            if (good_q == 2'd3) state_q <= StHlock;
                        end else if (line_err || h_fall) begin
                            good_q <= '0;
                        end
                    end
                    StHlock: begin
                        if (line_err) begin
                            state_q <= StSearch;
                            h_err   <= 1'b1;
                        end else if (v_fall) begin
                            state_q <= StTrack;
                        end
                    end
                    StTrack: begin
                        if (line_err) h_err <= 1'b1;
                        if (frame_err) v_err <= 1'b1;
                        if (line_err || frame_err) state_q <= StSearch;
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [23:0] acc_q, sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            sum_q <= '0;
        end else if (pix_en) begin
            if (done_n) sum_q <= acc_q;
            if (!track_n || done_n) begin
                acc_q <= '0;
            end else if (act_n) begin
                acc_q <= acc_q + {12'd0, VGA_R, VGA_G, VGA_B};
            end
        end
    end

    assign frame_sum = sum_q;
`else
    logic unused_rgb;
    assign unused_rgb = ^{VGA_R, VGA_G, VGA_B};
    assign frame_sum  = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a scaled-down timing (8x7 total) with a frame scoreboard.
module tb_vga_sync_monitor;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 2, VB = 1;
    localparam int HTOT = HV + HF + HS + HB;
    localparam int VTOT = VV + VF + VS + VB;
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0;
    logic        hSync = 1'b1;
    logic        vSync = 1'b1;
    logic [3:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic        locked, h_err, v_err, active, frame_done;
    logic [9:0]  x, y;
    logic [23:0] frame_sum;
    logic [7:0]  frame_cnt;

    typedef struct packed {
        logic [23:0] sum;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          duty = 1;
    int          gframe = 0;
    logic [7:0]  exp_cnt = '0;
    logic [9:0]  lx = '0, ly = '0;

    vga_sync_monitor #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .locked(locked), .h_err(h_err), .v_err(v_err), .active(active),
        .x(x), .y(y), .frame_done(frame_done), .frame_sum(frame_sum), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_h_err"}, h_err, 0);
        chk({tag, "_v_err"}, v_err, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_frame_sum"}, frame_sum, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // Drives n_lines lines of one frame; a frame_done for it is expected on the next frame's first tick.
    task automatic run_frame(input int vs_lines, input int short_line, input int n_lines,
                             input bit chk_win, input bit exp_done);
        logic [23:0] sum;
        logic [11:0] c;
        int          len;
        bit          vis;
        exp_t        e;
        sum = '0;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == short_line) ? HTOT - 1 : HTOT;
            for (int h = 0; h < len; h++) begin
                vis = (h >= HA0) && (h < HA0 + HV) && (l >= VA0) && (l < VA0 + VV);
                c = 12'(l * HTOT + h + gframe * 37);
                if (vis) sum = sum + {12'd0, c};
                hSync = (h >= HS);
                vSync = (l >= vs_lines);
                {VGA_R, VGA_G, VGA_B} = c;
                pix_en = 1'b1;
                @(posedge clk);
                #1;
                if (chk_win) begin
                    if (vis) begin
                        lx = 10'(h - HA0);
                        ly = 10'(l - VA0);
                    end
                    chk("active", active, vis);
                    chk("x", x, lx);
                    chk("y", y, ly);
                end
                if (short_line >= 0 && l == short_line && h == len - 1) begin
                    chk("locked_before_short", locked, 1);
                    chk("h_err_before_short", h_err, 0);
                end
                if (short_line >= 0 && l == short_line + 1 && h == 0) begin
                    chk("locked_after_short", locked, 0);
                    chk("h_err_after_short", h_err, 1);
                    chk("active_after_short", active, 0);
                end
                if (duty > 1) begin
                    pix_en = 1'b0;
                    repeat (duty - 1) @(posedge clk);
                    #1;
                end
            end
        end
        gframe++;
        if (exp_done) begin
            exp_cnt = exp_cnt + 8'd1;
`ifdef VGA_MON_CHECKSUM_EN
            e.sum = sum;
`else
            e.sum = '0;
`endif
            e.cnt = exp_cnt;
            sb.push_back(e);
        end
    endtask

    task automatic restart();
        #3;
        hSync = 1'b1;
        vSync = 1'b1;
        pix_en = 1'b0;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #4;
        reset = 1'b1;
        @(posedge clk);
        #1;
        gframe = 0;
        exp_cnt = '0;
        lx = '0;
        ly = '0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_frame_done", frame_done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_sum", frame_sum, e.sum);
                chk("frame_cnt", frame_cnt, e.cnt);
                chk("locked_at_done", locked, 1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Standard timing from reset: lock in frame 0, first frame_done after frame 1.
        run_frame(VS, -1, VTOT, 1'b0, 1'b0);
        run_frame(VS, -1, VTOT, 1'b1, 1'b1);
        run_frame(VS, -1, VTOT, 1'b0, 1'b1);

        // One short line: immediate unlock, relock two frames later.
        run_frame(VS, 3, VTOT, 1'b0, 1'b0);
        run_frame(VS, -1, VTOT, 1'b0, 1'b0);
        run_frame(VS, -1, VTOT, 1'b0, 1'b1);

        // Three-line vSync pulse: frame error, no frame_done for that frame.
        run_frame(3, -1, VTOT, 1'b0, 1'b0);
        chk("v_err_after_wide_vsync", v_err, 1);
        chk("locked_after_wide_vsync", locked, 0);
        chk("h_err_sticky", h_err, 1);
        run_frame(VS, -1, VTOT, 1'b0, 1'b0);
        run_frame(VS, -1, VTOT, 1'b0, 1'b1);
        run_frame(VS, -1, 3, 1'b0, 1'b0);
        chk("sb_drained_1", sb.size(), 0);
        chk("locked_before_reset", locked, 1);

        // Mid-frame reset, then a fresh lock with frame_cnt restarting at 1.
        restart();
        run_frame(VS, -1, VTOT, 1'b0, 1'b0);
        run_frame(VS, -1, VTOT, 1'b1, 1'b1);
        run_frame(VS, -1, 1, 1'b0, 1'b0);
        chk("sb_drained_2", sb.size(), 0);
        chk("h_err_cleared", h_err, 0);
        chk("v_err_cleared", v_err, 0);
        chk("locked_relock", locked, 1);

        // Same frames at 1-in-4 pixel enable, then run on until frame_cnt wraps.
        restart();
        duty = 4;
        run_frame(VS, -1, VTOT, 1'b0, 1'b0);
        run_frame(VS, -1, VTOT, 1'b1, 1'b1);
        run_frame(VS, -1, VTOT, 1'b0, 1'b1);
        duty = 1;
        for (int f = 0; f < 254; f++) begin
            run_frame(VS, -1, VTOT, 1'b0, 1'b1);
        end
        run_frame(VS, -1, 1, 1'b0, 1'b0);
        chk("sb_drained_3", sb.size(), 0);
        chk("frame_cnt_wrapped", frame_cnt, exp_cnt);
        chk("frame_cnt_zero", frame_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
